// File: rtl/chebyshev_pkg.sv
// chebyshev_pkg: shared state encoding, sizing helper and default widths for the Horner sequencer
package chebyshev_pkg;
  localparam int WL_DEF = 16;
  localparam int CL_DEF = 16;
  localparam int DEGREE_DEF = 7;
  localparam int LAT_DEF = 3;
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/chebyshev_sequencer_if.sv
// chebyshev_sequencer_if: sample-in / result-out valid-ready streams of the sequencer
interface chebyshev_sequencer_if #(parameter int WL = 16) ();
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/chebyshev_coeff_bank.sv
// chebyshev_coeff_bank: DEGREE+1 coefficient registers, gated writes, combinational read
module chebyshev_coeff_bank #(
  parameter int CL = 16,
  parameter int DEGREE = 7,
  parameter int AW = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [CL-1:0] wd_i,
  input  logic [AW-1:0] ra_i,
  output logic [CL-1:0] rd_o
);
  localparam logic [AW-1:0] DMAX = AW'(DEGREE);
  logic [CL-1:0] c_q [DEGREE+1];
  for (genvar i = 0; i <= DEGREE; i++) begin : g_c
    always_ff @(posedge clock or negedge resetn)
      if (!resetn) c_q[i] <= '0;
      else if (we_i && wa_i == AW'(i)) c_q[i] <= wd_i;
  end
  assign rd_o = (ra_i <= DMAX) ? c_q[ra_i] : '0;
endmodule

// File: rtl/chebyshev_sequencer.sv
// chebyshev_sequencer: paces Horner steps into the multiply-add datapath and returns p(x)
module chebyshev_sequencer
  import chebyshev_pkg::*;
#(
  parameter int WL = WL_DEF,
  parameter int CL = CL_DEF,
  parameter int DEGREE = DEGREE_DEF,
  parameter int LAT = LAT_DEF,
  parameter int AW = clog2(DEGREE + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cf_we,
  input  logic [AW-1:0] cf_addr,
  input  logic [CL-1:0] cf_wdata,
  chebyshev_sequencer_if.slave s,
  output logic [WL-1:0] dp_data,
  output logic [CL-1:0] dp_coeff,
  output logic          dp_clear,
  input  logic [WL-1:0] dp_result,
  output logic          busy
);
  localparam int CW = clog2(LAT);
  localparam logic [AW-1:0] DMAX = AW'(DEGREE);
  localparam logic [CW-1:0] CLAST = CW'(LAT - 1);
  state_t state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WL-1:0] data_q, data_d, od_q, od_d;
  logic [CL-1:0] coeff_q, coeff_d, rd;
  logic clear_q, clear_d, ov_q, ov_d;
  logic idle, step, last, accept, adv, fin, ack;
  assign idle   = state_q == IDLE;
  assign step   = state_q == STEP;
  assign last   = cnt_q == CLAST;
  assign accept = idle & s.in_valid;
  assign adv    = step & last & (k_q != '0);
  assign fin    = step & last & (k_q == '0);
  assign ack    = (state_q == DONE) & s.out_ready;
  chebyshev_coeff_bank #(.CL(CL), .DEGREE(DEGREE), .AW(AW)) u_bank (
    .clock(clock),
    .resetn(resetn),
    .we_i(cf_we & idle),
    .wa_i(cf_addr),
    .wd_i(cf_wdata),
    .ra_i(idle ? DMAX : k_q - AW'(1)),
    .rd_o(rd)
  );
  always_comb begin
    state_d = accept ? STEP : fin ? DONE : ack ? IDLE : state_q;
    k_d     = accept ? DMAX : adv ? k_q - AW'(1) : k_q;
    cnt_d   = accept ? '0 : step ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    data_d  = accept ? s.in_data : data_q;
    coeff_d = (accept | adv) ? rd : coeff_q;
    clear_d = accept ? 1'b1 : adv ? 1'b0 : clear_q;
    od_d    = fin ? dp_result : od_q;
    ov_d    = fin ? 1'b1 : ack ? 1'b0 : ov_q;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      coeff_q <= '0;
      clear_q <= 1'b0;
      od_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      coeff_q <= coeff_d;
      clear_q <= clear_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
    end
  assign s.in_ready  = idle;
  assign s.out_valid = ov_q;
  assign s.out_data  = od_q;
  assign dp_data     = data_q;
  assign dp_coeff    = coeff_q;
  assign dp_clear    = clear_q;
  assign busy        = !idle;
endmodule
